// File: rtl/roll_over_counter_if.sv
// ============================================================================
// roll_over_counter_if : limit-update valid/ready channel of roll_over_counter
// Rev 1.0
// ============================================================================
`default_nettype none

interface roll_over_counter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_limit;
  logic             i_limit_valid;
  logic             o_limit_ready;

  modport master (
    output i_limit,
    output i_limit_valid,
    input  o_limit_ready
  );

  modport slave (
    input  i_limit,
    input  i_limit_valid,
    output o_limit_ready
  );
endinterface

`default_nettype wire

// File: rtl/roll_over_counter.sv
// ============================================================================
// roll_over_counter : programmable prescaler, period = limit+1 clocks, with
// wrap-aligned limit updates. Optional pulse statistics: ROLL_OVER_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module roll_over_counter #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_LIMIT = 4
) (
  input  wire               i_clk,
  input  wire               i_reset,
  input  wire               i_enable,
  roll_over_counter_if.slave lim,
`ifdef ROLL_OVER_STATS_EN
  input  wire               i_stats_clr,
  output logic [15:0]       o_roll_cnt,
`endif
  output logic              o_roll_over,
  output logic [WIDTH-1:0]  o_count
);

  localparam logic [1:0] STOP  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WIDTH-1:0] LIMIT_MIN = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] active_limit;
  logic [WIDTH-1:0] pending_limit;
  logic             pending_valid;

  logic             accept;
  logic [WIDTH-1:0] new_limit;
  logic             counting;
  logic             wrap;

  assign lim.o_limit_ready = ~pending_valid;
  assign accept    = lim.i_limit_valid & ~pending_valid;
  assign new_limit = (lim.i_limit == '0) ? LIMIT_MIN : lim.i_limit;
  // The edge that leaves STOP/PAUSE only changes state; counting starts one edge later.
  assign counting  = (state == RUN) & i_enable;
  assign wrap      = counting & (o_count == active_limit);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= STOP;
      o_count       <= '0;
      o_roll_over   <= 1'b0;
      active_limit  <= LIMIT_RST;
      pending_limit <= '0;
      pending_valid <= 1'b0;
    end else begin
      o_roll_over <= wrap;

      case (state)
        STOP:    if (i_enable)  state <= RUN;
        RUN:     if (!i_enable) state <= PAUSE;
        PAUSE:   if (i_enable)  state <= RUN;
        default: state <= STOP;
      endcase

      if (wrap) begin
        o_count <= '0;
        if (pending_valid) begin
          active_limit  <= pending_limit;
          pending_valid <= 1'b0;
        end
      end else if (counting) begin
        o_count <= o_count + 1'b1;
      end

      // Accepting while running is deferred to the next wrap; otherwise it applies directly.
      if (accept) begin
        if (state == RUN) begin
          pending_limit <= new_limit;
          pending_valid <= 1'b1;
        end else begin
          active_limit <= new_limit;
          if (o_count > new_limit) o_count <= '0;
        end
      end
    end
  end

`ifdef ROLL_OVER_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_roll_cnt <= '0;
    end else if (i_stats_clr) begin
      o_roll_cnt <= '0;
    end else if (o_roll_over && (o_roll_cnt != 16'hFFFF)) begin
      o_roll_cnt <= o_roll_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_roll_over_counter.sv
// ============================================================================
// tb_roll_over_counter : scoreboard bench; expected pulse cycles are queued by
// the stimulus and matched by an independent monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_roll_over_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       roll_over;
  logic [7:0] count;
`ifdef ROLL_OVER_STATS_EN
  logic        stats_clr;
  logic [15:0] roll_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];

  roll_over_counter_if #(.WIDTH(8)) lim_if ();

  roll_over_counter #(.WIDTH(8), .DEFAULT_LIMIT(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .lim         (lim_if),
`ifdef ROLL_OVER_STATS_EN
    .i_stats_clr (stats_clr),
    .o_roll_cnt  (roll_cnt),
`endif
    .o_roll_over (roll_over),
    .o_count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed pulse must match the oldest expected pulse cycle.
  always @(negedge clk) begin
    if (roll_over === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          failures = failures + 1;
          $display("FAIL pulse_cycle: got pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e;
    int e2;
    int f;
    int g;
    int npulse;

    reset                = 1'b1;
    enable               = 1'b0;
    lim_if.i_limit       = 8'd0;
    lim_if.i_limit_valid = 1'b0;
`ifdef ROLL_OVER_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(2);
    check("reset_count", int'(count), 0);
    check("reset_roll", int'(roll_over), 0);
    check("reset_ready", int'(lim_if.o_limit_ready), 1);
`ifdef ROLL_OVER_STATS_EN
    check("reset_roll_cnt", int'(roll_cnt), 0);
`endif
    reset = 1'b0;
    tick(1);

    // Default limit 4: first pulse 6 edges after enabling, then every 5.
    e = cyc;
    enable = 1'b1;
    exp_q.push_back(e + 6);
    exp_q.push_back(e + 11);
    exp_q.push_back(e + 21);
    tick(14);
    check("pre_pause_count", int'(count), 3);
    enable = 1'b0;
    tick(4);
    check("pause_hold_count", int'(count), 3);
    check("pause_no_pulse", int'(roll_over), 0);
    enable = 1'b1;
    tick(2);
    check("resume_count", int'(count), 4);
    tick(2);

    // Limit 2 offered at count 1 while running: current period stays 5.
    check("ready_before_offer", int'(lim_if.o_limit_ready), 1);
    lim_if.i_limit       = 8'd2;
    lim_if.i_limit_valid = 1'b1;
    tick(1);
    lim_if.i_limit_valid = 1'b0;
    check("ready_drops", int'(lim_if.o_limit_ready), 0);
    check("count_after_offer", int'(count), 2);
    exp_q.push_back(e + 26);
    exp_q.push_back(e + 29);
    exp_q.push_back(e + 32);
    tick(3);
    check("ready_after_apply", int'(lim_if.o_limit_ready), 1);
    check("count_at_apply", int'(count), 0);
    tick(7);
    check("count_limit2", int'(count), 1);

    // Pending limit then async reset mid-period.
    lim_if.i_limit       = 8'd7;
    lim_if.i_limit_valid = 1'b1;
    tick(1);
    lim_if.i_limit_valid = 1'b0;
    check("pending_ready", int'(lim_if.o_limit_ready), 0);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_roll", int'(roll_over), 0);
    check("async_reset_ready", int'(lim_if.o_limit_ready), 1);
    check("queue_drained_1", exp_q.size(), 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // Limit back to 4 after reset.
    e2 = cyc;
    enable = 1'b1;
    exp_q.push_back(e2 + 6);
    exp_q.push_back(e2 + 11);
    tick(12);
    check("post_reset_count", int'(count), 1);

    // Limit 0 offered in STOP clamps to 1: pulse every 2 clocks.
    reset  = 1'b1;
    enable = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    f = cyc;
    lim_if.i_limit       = 8'd0;
    lim_if.i_limit_valid = 1'b1;
    tick(1);
    lim_if.i_limit_valid = 1'b0;
    check("stop_apply_ready", int'(lim_if.o_limit_ready), 1);
    enable = 1'b1;
    exp_q.push_back(f + 4);
    exp_q.push_back(f + 6);
    exp_q.push_back(f + 8);
    tick(8);
    check("limit1_count", int'(count), 1);

    // Limit below current count while paused clears the count with no pulse.
    reset  = 1'b1;
    enable = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    g = cyc;
    enable = 1'b1;
    tick(4);
    check("g_count3", int'(count), 3);
    enable = 1'b0;
    tick(1);
    lim_if.i_limit       = 8'd2;
    lim_if.i_limit_valid = 1'b1;
    tick(1);
    lim_if.i_limit_valid = 1'b0;
    check("pause_apply_clear", int'(count), 0);
    check("pause_apply_ready", int'(lim_if.o_limit_ready), 1);
    enable = 1'b1;
`ifdef ROLL_OVER_STATS_EN
    npulse = 11;
`else
    npulse = 2;
`endif
    for (int k = 0; k < npulse; k++) exp_q.push_back(g + 10 + 3 * k);
`ifdef ROLL_OVER_STATS_EN
    tick(32);
    check("roll_cnt_10", int'(roll_cnt), 10);
    tick(2);
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    check("roll_cnt_clr", int'(roll_cnt), 0);
    tick(1);
`else
    tick(9);
`endif
    // Count sits at the limit; dropping enable now must suppress the wrap.
    check("pre_fall_count", int'(count), 2);
    enable = 1'b0;
    tick(4);
    check("fall_hold_count", int'(count), 2);
    check("queue_drained_2", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
